// File: rtl/dcache_ctl.sv
// Direct-mapped write-through data cache with burst line refill.
// Single stall output freezes the PC while memory is busy.
module dcache_ctl #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        hit,
   output logic        stall,
   output logic        mem_rd,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr,
   input  logic        mem_wdone,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] miss_cnt
);

   localparam int OB  = $clog2(WORDS);
   localparam int IB  = $clog2(LINES);
   localparam int OBW = (OB > 0) ? OB : 1;
   localparam int TW  = 30 - OB - IB;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REFILL = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;

   logic [1:0]     state;
   logic [OBW-1:0] beat;
   logic [LINES-1:0] valid;
   logic [31:0]    data [LINES][WORDS];
   logic [TW-1:0]  tags [LINES];

   logic [IB-1:0]  idx;
   logic [OBW-1:0] off;
   logic [TW-1:0]  tag;
   logic           last;
   logic           unused_bits;

   assign idx  = cpu_addr[2+OB +: IB];
   assign off  = (OB == 0) ? '0 : cpu_addr[2 +: OBW];
   assign tag  = cpu_addr[31 -: TW];
   assign last = (beat == OBW'(WORDS - 1));
   assign unused_bits = ^cpu_addr[1:0];

   assign hit       = valid[idx] && (tags[idx] == tag);
   assign cpu_rdata = data[idx][off];

   assign mem_rd    = (state == S_REFILL);
   assign mem_wr    = (state == S_WRITE);
   assign mem_wdata = cpu_wdata;

   // Gated by reset so a held load request cannot stall during reset.
   assign stall = reset &&
                  ((state == S_REFILL) ||
                   (state == S_WRITE && !mem_wdone) ||
                   (state == S_IDLE && (cpu_wr || (cpu_rd && !hit))));

   always_comb begin
      mem_addr = 32'h0;
      case (state)
         S_REFILL: mem_addr = ({cpu_addr[31:2], 2'b00}
                               & ~(32'(WORDS - 1) << 2))
                              | (32'(beat) << 2);
         S_WRITE:  mem_addr = {cpu_addr[31:2], 2'b00};
         default:  mem_addr = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         beat     <= '0;
         valid    <= '0;
         miss_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_wr) begin
                  state <= S_WRITE;
               end else if (cpu_rd && !hit) begin
                  state      <= S_REFILL;
                  beat       <= '0;
                  valid[idx] <= 1'b0;
                  miss_cnt   <= miss_cnt + 16'd1;
               end
            end
            S_REFILL: begin
               if (mem_rdy) begin
                  if (last) begin
                     beat       <= '0;
                     valid[idx] <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (mem_wdone) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (state == S_REFILL && mem_rdy) begin
         data[idx][beat] <= mem_rdata;
         if (last) tags[idx] <= tag;
      end
      if (state == S_WRITE && mem_wdone && hit)
         data[idx][off] <= cpu_wdata;
   end

endmodule

// File: tb/tb_dcache_ctl.sv
// Directed bench for dcache_ctl (LINES=16, WORDS=4).
// Memory returns a fixed function of the word address.
module tb_dcache_ctl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        hit, stall;
   logic        mem_rd, mem_rdy, mem_wr, mem_wdone;
   logic [31:0] mem_rdata, mem_addr, mem_wdata;
   logic [15:0] miss_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_cycles;

   dcache_ctl #(.LINES(16), .WORDS(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .hit(hit), .stall(stall),
      .mem_rd(mem_rd), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
      .mem_wr(mem_wr), .mem_wdone(mem_wdone),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mword(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents a load that must miss, then serves the whole line.
   task automatic read_miss(input logic [31:0] a,
                            input logic [15:0] cnt);
      logic [31:0] base;
      base     = {a[31:4], 4'h0};
      cpu_rd   = 1'b1;
      cpu_addr = a;
      #1;
      check("miss_hit", 32'(hit), 32'd0);
      check("miss_stall", 32'(stall), 32'd1);
      tick;
      for (int i = 0; i < 4; i++) begin
         check("ref_rd", 32'(mem_rd), 32'd1);
         check("ref_stall", 32'(stall), 32'd1);
         check("ref_addr", mem_addr, base + 32'(4 * i));
         mem_rdy   = 1'b1;
         mem_rdata = mword(base + 32'(4 * i));
         tick;
      end
      mem_rdy = 1'b0;
      #1;
      check("fill_stall", 32'(stall), 32'd0);
      check("fill_hit", 32'(hit), 32'd1);
      check("fill_rd", 32'(mem_rd), 32'd0);
      check("fill_rdata", cpu_rdata, mword({a[31:2], 2'b00}));
      check("miss_cnt", 32'(miss_cnt), 32'(cnt));
   endtask

   initial begin
      reset     = 1'b0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      mem_rdy   = 1'b0;
      mem_rdata = 32'h0;
      mem_wdone = 1'b0;
      tick;
      check("rst_rd", 32'(mem_rd), 32'd0);
      check("rst_wr", 32'(mem_wr), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_cnt", 32'(miss_cnt), 32'd0);
      reset = 1'b1;
      tick;

      read_miss(32'h0000_0104, 16'd1);

      cpu_addr = 32'h0000_0108;
      #1;
      check("rh_hit", 32'(hit), 32'd1);
      check("rh_stall", 32'(stall), 32'd0);
      check("rh_rdata", cpu_rdata, mword(32'h108));
      tick;
      check("rh_memrd", 32'(mem_rd), 32'd0);

      cpu_rd    = 1'b0;
      cpu_wr    = 1'b1;
      cpu_addr  = 32'h0000_0104;
      cpu_wdata = 32'hDEAD_BEEF;
      #1;
      check("st_hit", 32'(hit), 32'd1);
      check("st_idle_stall", 32'(stall), 32'd1);
      check("st_idle_wr", 32'(mem_wr), 32'd0);
      tick;
      wr_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem_wr) wr_cycles++;
         check("st_addr", mem_addr, 32'h104);
         check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
         mem_wdone = (i == 3);
         #1;
         check("st_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
         tick;
      end
      check("st_wr_cycles", 32'(wr_cycles), 32'd4);
      check("st_wr_done", 32'(mem_wr), 32'd0);
      cpu_wr    = 1'b0;
      mem_wdone = 1'b0;
      cpu_rd    = 1'b1;
      #1;
      check("st_rb_hit", 32'(hit), 32'd1);
      check("st_rb_stall", 32'(stall), 32'd0);
      check("st_rb_data", cpu_rdata, 32'hDEAD_BEEF);
      tick;

      cpu_rd    = 1'b0;
      cpu_wr    = 1'b1;
      cpu_addr  = 32'h0000_2000;
      cpu_wdata = 32'h0BAD_F00D;
      #1;
      check("wm_hit", 32'(hit), 32'd0);
      tick;
      check("wm_wr", 32'(mem_wr), 32'd1);
      check("wm_addr", mem_addr, 32'h2000);
      check("wm_wdata", mem_wdata, 32'h0BAD_F00D);
      mem_wdone = 1'b1;
      #1;
      check("wm_stall", 32'(stall), 32'd0);
      tick;
      cpu_wr    = 1'b0;
      mem_wdone = 1'b0;
      #1;
      check("wm_after_hit", 32'(hit), 32'd0);
      check("wm_old_line", 32'(miss_cnt), 32'd1);
      read_miss(32'h0000_2000, 16'd2);
      tick;

      read_miss(32'h0000_0104, 16'd3);
      tick;
      read_miss(32'h0000_1104, 16'd4);
      cpu_addr = 32'h0000_0104;
      #1;
      check("cf_hit", 32'(hit), 32'd0);
      check("cf_stall", 32'(stall), 32'd1);
      tick;

      for (int i = 0; i < 2; i++) begin
         check("pr_addr", mem_addr, 32'h100 + 32'(4 * i));
         mem_rdy   = 1'b1;
         mem_rdata = mword(32'h100 + 32'(4 * i));
         tick;
      end
      mem_rdy = 1'b0;
      check("pr_rd_before", 32'(mem_rd), 32'd1);
      reset = 1'b0;
      #1;
      check("pr_rd", 32'(mem_rd), 32'd0);
      check("pr_stall", 32'(stall), 32'd0);
      check("pr_hit", 32'(hit), 32'd0);
      check("pr_cnt", 32'(miss_cnt), 32'd0);
      tick;
      reset = 1'b1;
      tick;
      read_miss(32'h0000_0104, 16'd1);
      cpu_rd = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
